// File: rtl/reg_read_port_if.sv
// Read handshake between reg_read_port and its consumer.
// master: consumer side (issues requests, acknowledges data).
// slave : reg_read_port side (returns registered A/B data).
interface reg_read_port_if #(
    parameter int DATA_W = 16
) ();

    logic              rd_req;
    logic [3:0]        addr_a;
    logic [3:0]        addr_b;
    logic              rd_ack;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;

    modport master (
        output rd_req,
        output addr_a,
        output addr_b,
        output rd_ack,
        input  rd_ready,
        input  rd_valid,
        input  A,
        input  B
    );

    modport slave (
        input  rd_req,
        input  addr_a,
        input  addr_b,
        input  rd_ack,
        output rd_ready,
        output rd_valid,
        output A,
        output B
    );

endinterface

// File: rtl/reg_read_port.sv
// Dual read port into a 16-entry register bank.
// A request captures two indices; the following edge loads both ports from
// the bank and the result is held until the consumer acknowledges it.
// Build option: define REG_READ_BYPASS_EN to forward a same-edge register
// write (regEnable/ALUBus) into the port being loaded.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready for a request; A/B keep the last completed read
//   READ  | indices captured; A/B load from the bank on the next edge
//   HOLD  | A/B valid and frozen until rd_ack
module reg_read_port #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] r0,
    input  logic [DATA_W-1:0] r1,
    input  logic [DATA_W-1:0] r2,
    input  logic [DATA_W-1:0] r3,
    input  logic [DATA_W-1:0] r4,
    input  logic [DATA_W-1:0] r5,
    input  logic [DATA_W-1:0] r6,
    input  logic [DATA_W-1:0] r7,
    input  logic [DATA_W-1:0] r8,
    input  logic [DATA_W-1:0] r9,
    input  logic [DATA_W-1:0] r10,
    input  logic [DATA_W-1:0] r11,
    input  logic [DATA_W-1:0] r12,
    input  logic [DATA_W-1:0] r13,
    input  logic [DATA_W-1:0] r14,
    input  logic [DATA_W-1:0] r15,
    input  logic [DATA_W-1:0] ALUBus,
    input  logic [15:0]       regEnable,
    reg_read_port_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [3:0]        r_idx_a;
    logic [3:0]        r_idx_b;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_valid;

    logic              w_capture;
    logic              w_load;
    logic              w_release;
    logic              w_rd_ready;

    logic [DATA_W-1:0] w_bank [16];
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    // Flatten the register bank inputs so the latched indices can select them.
    always_comb begin
        w_bank[0]  = r0;
        w_bank[1]  = r1;
        w_bank[2]  = r2;
        w_bank[3]  = r3;
        w_bank[4]  = r4;
        w_bank[5]  = r5;
        w_bank[6]  = r6;
        w_bank[7]  = r7;
        w_bank[8]  = r8;
        w_bank[9]  = r9;
        w_bank[10] = r10;
        w_bank[11] = r11;
        w_bank[12] = r12;
        w_bank[13] = r13;
        w_bank[14] = r14;
        w_bank[15] = r15;
    end

`ifdef REG_READ_BYPASS_EN
    // A register being written on the load edge returns the incoming value.
    always_comb begin
        w_rd_a = regEnable[r_idx_a] ? ALUBus : w_bank[r_idx_a];
        w_rd_b = regEnable[r_idx_b] ? ALUBus : w_bank[r_idx_b];
    end
`else
    logic w_unused_bypass;

    // Without forwarding the read returns the pre-write bank contents.
    always_comb begin
        w_rd_a = w_bank[r_idx_a];
        w_rd_b = w_bank[r_idx_b];
    end

    assign w_unused_bypass = ^{regEnable, ALUBus};
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode; a request is only taken while ready,
    // so requests arriving during READ or an unacknowledged HOLD are dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_load      = 1'b0;
        w_release   = 1'b0;
        w_rd_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                w_rd_ready = 1'b1;
                if (bus.rd_req) begin
                    w_capture   = 1'b1;
                    w_state_nxt = READ;
                end
            end
            READ: begin
                w_load      = 1'b1;
                w_state_nxt = HOLD;
            end
            HOLD: begin
                if (bus.rd_ack) begin
                    w_rd_ready = 1'b1;
                    w_release  = 1'b1;
                    if (bus.rd_req) begin
                        w_capture   = 1'b1;
                        w_state_nxt = READ;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Index capture; later address changes do not disturb a read in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx_a <= 4'd0;
            r_idx_b <= 4'd0;
        end else if (w_capture) begin
            r_idx_a <= bus.addr_a;
            r_idx_b <= bus.addr_b;
        end
    end

    // Output data: loaded once per read, otherwise frozen (also after release).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a <= '0;
            r_b <= '0;
        end else if (w_load) begin
            r_a <= w_rd_a;
            r_b <= w_rd_b;
        end
    end

    // Valid flag: set by the load, cleared when the consumer acknowledges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
        end else if (w_release) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.rd_ready = w_rd_ready;
    assign bus.rd_valid = r_valid;
    assign bus.A        = r_a;
    assign bus.B        = r_b;

endmodule

// File: tb/tb_reg_read_port.sv
// Self-checking bench for reg_read_port: directed scenarios plus a randomized
// run against a transaction-level model of the read handshake.
module tb_reg_read_port;

    logic        clk;
    logic        reset;
    logic [15:0] bank [16];
    logic [15:0] ALUBus;
    logic [15:0] regEnable;

    int total = 0;
    int bad   = 0;

    reg_read_port_if #(.DATA_W(16)) bus ();

    reg_read_port #(.DATA_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .r0        (bank[0]),
        .r1        (bank[1]),
        .r2        (bank[2]),
        .r3        (bank[3]),
        .r4        (bank[4]),
        .r5        (bank[5]),
        .r6        (bank[6]),
        .r7        (bank[7]),
        .r8        (bank[8]),
        .r9        (bank[9]),
        .r10       (bank[10]),
        .r11       (bank[11]),
        .r12       (bank[12]),
        .r13       (bank[13]),
        .r14       (bank[14]),
        .r15       (bank[15]),
        .ALUBus    (ALUBus),
        .regEnable (regEnable),
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Value a port should return for index idx at the load edge.
    function automatic logic [15:0] m_read(input logic [3:0] idx);
`ifdef REG_READ_BYPASS_EN
        if (regEnable[idx]) return ALUBus;
`endif
        return bank[idx];
    endfunction

    task automatic test_reset();
        reset       = 1'b0;
        bus.rd_req  = 1'b0;
        bus.rd_ack  = 1'b0;
        bus.addr_a  = 4'd0;
        bus.addr_b  = 4'd0;
        ALUBus      = 16'h0;
        regEnable   = 16'h0;
        for (int k = 0; k < 16; k++) bank[k] = 16'(k * 16'h0101);
        tick();
        tick();
        total++;
        if ({bus.A, bus.B} !== 32'h0) begin
            bad++;
            $display("FAIL reset_ab: got %h/%h expected 0000/0000", bus.A, bus.B);
        end
        total++;
        if (bus.rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid: got %b expected 0", bus.rd_valid);
        end
        total++;
        if (bus.rd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b expected 1", bus.rd_ready);
        end
    endtask

    task automatic test_basic_read();
        reset      = 1'b1;
        bank[3]    = 16'h1234;
        bank[7]    = 16'hBEEF;
        bus.rd_req = 1'b1;
        bus.addr_a = 4'd3;
        bus.addr_b = 4'd7;
        tick();
        bus.rd_req = 1'b0;
        bus.addr_a = 4'd9;
        bus.addr_b = 4'd1;
        total++;
        if ({bus.rd_valid, bus.rd_ready} !== 2'b00) begin
            bad++;
            $display("FAIL read_phase: got valid=%b ready=%b expected 0/0", bus.rd_valid, bus.rd_ready);
        end
        tick();
        total++;
        if ({bus.rd_valid, bus.A, bus.B} !== {1'b1, 16'h1234, 16'hBEEF}) begin
            bad++;
            $display("FAIL basic_read: got v=%b %h/%h expected 1 1234/BEEF", bus.rd_valid, bus.A, bus.B);
        end
    endtask

    task automatic test_hold_stable();
        bank[3] = 16'h0000;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if ({bus.rd_valid, bus.rd_ready, bus.A} !== {1'b1, 1'b0, 16'h1234}) begin
                bad++;
                $display("FAIL hold_stable[%0d]: got v=%b rdy=%b A=%h expected 1 0 1234", c, bus.rd_valid, bus.rd_ready, bus.A);
            end
        end
    endtask

    task automatic test_back_to_back();
        bank[5]    = 16'h00A5;
        bus.rd_ack = 1'b1;
        bus.rd_req = 1'b1;
        bus.addr_a = 4'd5;
        bus.addr_b = 4'd5;
        #1;
        total++;
        if (bus.rd_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready: got %b expected 1", bus.rd_ready);
        end
        tick();
        bus.rd_ack = 1'b0;
        bus.rd_req = 1'b0;
        total++;
        if ({bus.rd_valid, bus.A} !== {1'b0, 16'h1234}) begin
            bad++;
            $display("FAIL b2b_gap: got v=%b A=%h expected 0 1234", bus.rd_valid, bus.A);
        end
        tick();
        total++;
        if ({bus.rd_valid, bus.A, bus.B} !== {1'b1, 16'h00A5, 16'h00A5}) begin
            bad++;
            $display("FAIL b2b_data: got v=%b %h/%h expected 1 00A5/00A5", bus.rd_valid, bus.A, bus.B);
        end
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack = 1'b0;
        #1;
        total++;
        if ({bus.rd_valid, bus.rd_ready, bus.A, bus.B} !== {2'b01, 16'h00A5, 16'h00A5}) begin
            bad++;
            $display("FAIL ack_release: got v=%b rdy=%b %h/%h expected 0 1 00A5/00A5", bus.rd_valid, bus.rd_ready, bus.A, bus.B);
        end
    endtask

    task automatic test_bypass();
        logic [15:0] exp_a;
        bank[2]    = 16'h1111;
        bank[9]    = 16'h9999;
        bus.rd_req = 1'b1;
        bus.addr_a = 4'd2;
        bus.addr_b = 4'd9;
        tick();
        bus.rd_req = 1'b0;
        regEnable  = 16'h0004;
        ALUBus     = 16'h5A5A;
`ifdef REG_READ_BYPASS_EN
        exp_a = 16'h5A5A;
`else
        exp_a = 16'h1111;
`endif
        tick();
        regEnable = 16'h0000;
        total++;
        if ({bus.rd_valid, bus.A, bus.B} !== {1'b1, exp_a, 16'h9999}) begin
            bad++;
            $display("FAIL bypass: got v=%b %h/%h expected 1 %h/9999", bus.rd_valid, bus.A, bus.B, exp_a);
        end
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        bus.rd_req = 1'b1;
        bus.addr_a = 4'd7;
        bus.addr_b = 4'd3;
        tick();
        bus.rd_req = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        total++;
        if ({bus.rd_valid, bus.rd_ready, bus.A, bus.B} !== {2'b01, 32'h0}) begin
            bad++;
            $display("FAIL reset_mid_read: got v=%b rdy=%b %h/%h expected 0 1 0000/0000", bus.rd_valid, bus.rd_ready, bus.A, bus.B);
        end
        tick();
        #2;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if ({bus.rd_valid, bus.rd_ready, bus.A} !== {2'b01, 16'h0}) begin
                bad++;
                $display("FAIL post_reset[%0d]: got v=%b rdy=%b A=%h expected 0 1 0000", c, bus.rd_valid, bus.rd_ready, bus.A);
            end
        end
    endtask

    task automatic test_ignore_req();
        int rises;
        logic prev;
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack = 1'b0;
        total++;
        if ({bus.rd_valid, bus.rd_ready, bus.A} !== {2'b01, 16'h0}) begin
            bad++;
            $display("FAIL ack_in_idle: got v=%b rdy=%b A=%h expected 0 1 0000", bus.rd_valid, bus.rd_ready, bus.A);
        end
        bank[4]    = 16'h4444;
        bank[6]    = 16'h6666;
        bank[8]    = 16'h8888;
        bank[10]   = 16'hAAAA;
        bus.rd_req = 1'b1;
        bus.addr_a = 4'd4;
        bus.addr_b = 4'd6;
        tick();
        bus.addr_a = 4'd8;
        bus.addr_b = 4'd10;
        tick();
        bus.rd_req = 1'b0;
        total++;
        if ({bus.rd_valid, bus.A, bus.B} !== {1'b1, 16'h4444, 16'h6666}) begin
            bad++;
            $display("FAIL first_read: got v=%b %h/%h expected 1 4444/6666", bus.rd_valid, bus.A, bus.B);
        end
        rises = 0;
        prev  = bus.rd_valid;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.rd_valid && !prev) rises++;
            prev = bus.rd_valid;
        end
        total++;
        if ({rises, bus.rd_valid, bus.A} !== {32'd0, 1'b1, 16'h4444}) begin
            bad++;
            $display("FAIL no_second_read: got rises=%0d v=%b A=%h expected 0 1 4444", rises, bus.rd_valid, bus.A);
        end
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack = 1'b0;
        rises = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.rd_valid) rises++;
        end
        total++;
        if (rises !== 0) begin
            bad++;
            $display("FAIL not_queued: got %0d valid cycles expected 0", rises);
        end
    endtask

    task automatic test_random();
        logic        m_pend;
        logic        m_valid;
        logic        m_ready;
        logic [3:0]  m_pa;
        logic [3:0]  m_pb;
        logic [15:0] m_a;
        logic [15:0] m_b;
        bus.rd_req = 1'b0;
        bus.rd_ack = 1'b0;
        reset      = 1'b0;
        tick();
        reset   = 1'b1;
        m_pend  = 1'b0;
        m_valid = 1'b0;
        m_a     = 16'h0;
        m_b     = 16'h0;
        m_pa    = 4'd0;
        m_pb    = 4'd0;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 16; k++) begin
                if ($urandom_range(3) == 0) bank[k] = 16'($urandom);
            end
            bus.rd_req = 1'($urandom_range(1));
            bus.rd_ack = 1'($urandom_range(1));
            bus.addr_a = 4'($urandom);
            bus.addr_b = ($urandom_range(3) == 0) ? bus.addr_a : 4'($urandom);
            regEnable  = ($urandom_range(1) == 1) ? 16'(32'd1 << $urandom_range(15)) : 16'h0;
            ALUBus     = 16'($urandom);
            #1;
            m_ready = !m_pend && (!m_valid || bus.rd_ack);
            total++;
            if (bus.rd_ready !== m_ready) begin
                bad++;
                $display("FAIL rand_ready[%0d]: got %b expected %b", c, bus.rd_ready, m_ready);
            end
            if (m_pend) begin
                m_a     = m_read(m_pa);
                m_b     = m_read(m_pb);
                m_valid = 1'b1;
                m_pend  = 1'b0;
            end else if (m_ready && bus.rd_req) begin
                m_pa    = bus.addr_a;
                m_pb    = bus.addr_b;
                m_pend  = 1'b1;
                m_valid = 1'b0;
            end else if (m_valid && bus.rd_ack) begin
                m_valid = 1'b0;
            end
            tick();
            total++;
            if ({bus.rd_valid, bus.A, bus.B} !== {m_valid, m_a, m_b}) begin
                bad++;
                $display("FAIL rand_data[%0d]: got v=%b %h/%h expected %b %h/%h", c, bus.rd_valid, bus.A, bus.B, m_valid, m_a, m_b);
            end
        end
        bus.rd_req = 1'b0;
        bus.rd_ack = 1'b0;
        regEnable  = 16'h0;
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_hold_stable();
        test_back_to_back();
        test_bypass();
        test_reset_mid_read();
        test_ignore_req();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_read_port.md
REG_READ_PORT -- requirements
Module: reg_read_port

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of every register and data bus.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports r0..r15  input  DATA_W each  current contents of the register bank.
REQ-005 SHALL have port ALUBus  input  DATA_W  write data being presented to the register bank.
REQ-006 SHALL have port regEnable  input  16  per-register write enables of the register bank.
REQ-007 SHALL have port rd_req  input  1  read request; sampled only when rd_ready=1.
REQ-008 SHALL have ports addr_a, addr_b  input  4 each  register indices for ports A and B.
REQ-009 SHALL have port rd_ack  input  1  consumer has taken A/B.
REQ-010 SHALL have port rd_ready  output  1  block can accept rd_req this cycle.
REQ-011 SHALL have port rd_valid  output  1  A/B hold a completed read.
REQ-012 SHALL have ports A, B  output  DATA_W each  read data, registered.

Function
REQ-013 SHALL implement FSM states IDLE, READ, HOLD.
REQ-014 IDLE: rd_ready=1; on rd_req=1 SHALL latch addr_a/addr_b and go to READ; else stay.
REQ-015 READ: rd_ready=0; SHALL load A=r[addr_a], B=r[addr_b] (latched indices), set rd_valid=1, go to HOLD.
REQ-016 Latency: rd_req sampled at edge N -> A/B/rd_valid updated at edge N+1.
REQ-017 HOLD: rd_valid=1, A/B SHALL remain stable regardless of r0..r15 changes until rd_ack=1.
REQ-018 HOLD with rd_ack=1, rd_req=0: SHALL clear rd_valid and go to IDLE; A/B keep last values.
REQ-019 HOLD with rd_ack=1, rd_req=1: SHALL latch new addresses, clear rd_valid, go to READ (back-to-back).
REQ-020 rd_ready SHALL be 1 in IDLE, and in HOLD when rd_ack=1 (combinational from state and rd_ack); 0 otherwise.
REQ-021 rd_req while rd_ready=0 SHALL be ignored (not queued).
REQ-022 rd_ack outside HOLD SHALL be ignored.
REQ-023 addr_a==addr_b SHALL yield A==B; all 16 indices valid, no out-of-range case.
REQ-024 Addresses changing after capture SHALL NOT affect the read in progress.

Reset
REQ-025 reset=0 SHALL asynchronously force state IDLE, A=0, B=0, rd_valid=0, latched indices=0.
REQ-026 Reset during READ or HOLD SHALL abort the read; no rd_valid pulse after release.
REQ-027 First rd_req SHALL be sampled at the first rising edge with reset=1.

Configuration
REQ-028 Macro REG_READ_BYPASS_EN SHALL control write-to-read forwarding.
REQ-029 Defined: in READ, if regEnable[idx]=1 for a latched index, that port SHALL load ALUBus instead of r[idx] (same-edge write visible).
REQ-030 Undefined: READ SHALL always load r[idx]; regEnable and ALUBus SHALL be unused (pre-write value returned).

Verification
REQ-031 Reset release, r3=16'h1234, r7=16'hBEEF, rd_req addr_a=3 addr_b=7 -> next edge A=16'h1234, B=16'hBEEF, rd_valid=1.
REQ-032 In HOLD without rd_ack, change r3 to 16'h0000 for 5 cycles -> A stays 16'h1234, rd_valid stays 1.
REQ-033 HOLD with rd_ack=1, rd_req=1, addr_a=addr_b=5, r5=16'h00A5 -> one cycle rd_valid=0, then A=B=16'h00A5, rd_valid=1.
REQ-034 READ cycle with regEnable=16'h0004, ALUBus=16'h5A5A, addr_a=2 (r2=16'h1111) -> A=16'h5A5A with REG_READ_BYPASS_EN, A=16'h1111 without.
REQ-035 reset=0 asserted mid-READ (between clock edges) -> A=B=0, rd_valid=0 immediately, state IDLE, rd_ready=1.
REQ-036 rd_req pulsed in READ state -> ignored; exactly one rd_valid assertion, no second read.
